// File: rtl/athena_hiscore_shadow_pkg.sv
// Shared types and constants for the Athena hiscore shadow block.
// No logic latency; no flow control.
// Address helpers are shared by capture and injection paths.
package athena;

    localparam logic [10:0] HISCORE_BASE = 11'h650;
    localparam int          HISCORE_SIZE = 114;

    typedef logic [6:0] hiscore_offset_t;

    typedef enum logic [1:0] {
        LOAD,
        WAIT_BASE,
        INJECT,
        DONE
    } hiscore_state_t;

    typedef struct packed {
        logic        nCS;
        logic        nWE;
        logic [15:0] addr;
        logic [7:0]  data_in;
    } side_ram_t;

    // Bounds are checked on the 11-bit difference so the table may sit anywhere.
    function automatic logic in_table(input logic [10:0] addr,
                                      input logic [10:0] base,
                                      input int          size);
        logic [10:0] diff;
        diff = addr - base;
        return (addr >= base) && (diff < 11'(size));
    endfunction

    function automatic hiscore_offset_t table_offset(input logic [10:0] addr,
                                                     input logic [10:0] base);
        logic [10:0] diff;
        diff = addr - base;
        return diff[6:0];
    endfunction

endpackage

// File: rtl/athena_hiscore_shadow_injector.sv
// Replays the restore buffer into side RAM one byte per idle game cycle.
// Issue is combinational with the monitor; GAP_CYCLES pass-through cycles follow each byte.
// Stalls whenever the game owns the bus; the game always wins.
module athena_hiscore_shadow_injector
    import athena::*;
#(
    parameter logic [10:0] BASE_ADDR  = HISCORE_BASE,
    parameter int          TABLE_SIZE = HISCORE_SIZE,
    parameter int          GAP_CYCLES = 1
) (
    input  logic            game_clk,
    input  logic            reset_n,
    input  logic            start,
    input  side_ram_t       side_ram_monitor,
    input  logic [7:0]      inj_data,
    output side_ram_t       side_ram_in,
    output logic            inj_wr,
    output hiscore_offset_t inj_off,
    output logic            inj_done
);

    localparam int              GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES);
    localparam hiscore_offset_t LAST_OFF = 7'(TABLE_SIZE - 1);

    logic            run_q;
    logic            all_wr_q;
    hiscore_offset_t off_q;
    logic [GW-1:0]   gap_q;
    logic [10:0]     inj_addr;

    assign inj_wr   = run_q & ~all_wr_q & (gap_q == '0) & side_ram_monitor.nCS;
    assign inj_off  = off_q;
    assign inj_addr = BASE_ADDR + {4'b0000, off_q};

    // Done fires in the last gap cycle so the FSM leaves INJECT right as the gap ends.
    assign inj_done = (GAP_CYCLES == 0) ? (inj_wr & (off_q == LAST_OFF))
                                        : (run_q & all_wr_q & (gap_q == GW'(1)));

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            all_wr_q <= 1'b0;
            off_q    <= '0;
            gap_q    <= '0;
        end else if (start) begin
            run_q    <= 1'b1;
            all_wr_q <= 1'b0;
            off_q    <= '0;
            gap_q    <= '0;
        end else if (run_q) begin
            if (inj_wr) begin
                gap_q <= GAP_LOAD;
                if (off_q == LAST_OFF) begin
                    all_wr_q <= 1'b1;
                end else begin
                    off_q <= off_q + 7'd1;
                end
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
            if (inj_done) begin
                run_q <= 1'b0;
            end
        end
    end

    always_comb begin
        side_ram_in = side_ram_monitor;
        if (inj_wr) begin
            side_ram_in.nCS     = 1'b0;
            side_ram_in.nWE     = 1'b0;
            side_ram_in.addr    = {5'b00000, inj_addr};
            side_ram_in.data_in = inj_data;
        end
    end

endmodule

// File: rtl/athena_hiscore_shadow.sv
// Athena hiscore shadow: captures game writes, restores a saved table, serves save reads.
// Save read data 1 cycle after save_rd; side RAM pass-through is zero latency.
// restore_ready drops on capture collisions; optional ATHENA_HISCORE_CHECKSUM_EN adds checksum.
module athena_hiscore_shadow
    import athena::*;
#(
    parameter logic [10:0] BASE_ADDR  = HISCORE_BASE,
    parameter int          TABLE_SIZE = HISCORE_SIZE,
    parameter int          GAP_CYCLES = 1
) (
    input  logic            game_clk,
    input  logic            reset_n,
    input  side_ram_t       side_ram_monitor,
    output side_ram_t       side_ram_in,
    input  logic            base_written,
    input  logic            restore_valid,
    input  hiscore_offset_t restore_offset,
    input  logic [7:0]      restore_data,
    output logic            restore_ready,
    input  logic            restore_done,
    input  logic            save_rd,
    input  hiscore_offset_t save_offset,
    output logic            save_rd_valid,
    output logic [7:0]      save_rd_data,
    output logic            busy,
    output logic            injected
`ifdef ATHENA_HISCORE_CHECKSUM_EN
    ,
    output logic [7:0]      checksum
`endif
);

    hiscore_state_t  state_q, state_d;
    logic [7:0]      shadow      [TABLE_SIZE];
    logic [7:0]      restore_buf [TABLE_SIZE];
    logic            any_loaded_q;

    logic            cap_hit;
    hiscore_offset_t cap_off;
    logic            rst_in_range;
    logic            rst_wr;
    logic            inj_start;
    logic            inj_wr;
    logic            inj_done;
    hiscore_offset_t inj_off;
    logic [7:0]      inj_data;

    logic            sh_we;
    hiscore_offset_t sh_off;
    logic [7:0]      sh_dat;

    assign cap_hit = ~side_ram_monitor.nCS & ~side_ram_monitor.nWE &
                     in_table(side_ram_monitor.addr[10:0], BASE_ADDR, TABLE_SIZE);
    assign cap_off = table_offset(side_ram_monitor.addr[10:0], BASE_ADDR);

    assign rst_in_range  = restore_offset < 7'(TABLE_SIZE);
    assign restore_ready = (state_q == LOAD) & ~cap_hit;
    assign rst_wr        = restore_valid & restore_ready & rst_in_range;

    assign busy     = (state_q == INJECT);
    assign injected = (state_q == DONE);
    assign inj_data = restore_buf[inj_off];

    always_comb begin
        state_d   = state_q;
        inj_start = 1'b0;
        case (state_q)
            LOAD: begin
                if (restore_done) begin
                    state_d = (any_loaded_q | rst_wr) ? WAIT_BASE : DONE;
                end
            end
            WAIT_BASE: begin
                if (base_written) begin
                    state_d   = INJECT;
                    inj_start = 1'b1;
                end
            end
            INJECT: begin
                if (inj_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q      <= LOAD;
            any_loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rst_wr) begin
                any_loaded_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge game_clk) begin
        if (rst_wr) begin
            restore_buf[restore_offset] <= restore_data;
        end
    end

    // Single shadow write port; capture and inject never coincide since inject needs nCS high.
    always_comb begin
        sh_we  = 1'b0;
        sh_off = '0;
        sh_dat = '0;
        if (cap_hit) begin
            sh_we  = 1'b1;
            sh_off = cap_off;
            sh_dat = side_ram_monitor.data_in;
        end else if (inj_wr) begin
            sh_we  = 1'b1;
            sh_off = inj_off;
            sh_dat = inj_data;
        end else if (rst_wr) begin
            sh_we  = 1'b1;
            sh_off = restore_offset;
            sh_dat = restore_data;
        end
    end

    always_ff @(posedge game_clk) begin
        if (sh_we) begin
            shadow[sh_off] <= sh_dat;
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            save_rd_valid <= 1'b0;
            save_rd_data  <= 8'h00;
        end else begin
            save_rd_valid <= save_rd;
            if (save_rd) begin
                save_rd_data <= (save_offset < 7'(TABLE_SIZE)) ? shadow[save_offset] : 8'hFF;
            end
        end
    end

`ifdef ATHENA_HISCORE_CHECKSUM_EN
    logic [7:0] csum_q;
    logic [7:0] sh_old;

    assign sh_old   = shadow[sh_off];
    assign checksum = csum_q;

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else if (sh_we) begin
            csum_q <= csum_q + sh_dat - sh_old;
        end
    end
`endif

    athena_hiscore_shadow_injector #(
        .BASE_ADDR  (BASE_ADDR),
        .TABLE_SIZE (TABLE_SIZE),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_injector (
        .game_clk         (game_clk),
        .reset_n          (reset_n),
        .start            (inj_start),
        .side_ram_monitor (side_ram_monitor),
        .inj_data         (inj_data),
        .side_ram_in      (side_ram_in),
        .inj_wr           (inj_wr),
        .inj_off          (inj_off),
        .inj_done         (inj_done)
    );

endmodule

// File: tb/tb_athena_hiscore_shadow.sv
// Directed bench for athena_hiscore_shadow: restore, inject, contention, range and reset cases.
module tb_athena_hiscore_shadow;
    import athena::*;

    logic            game_clk = 1'b0;
    logic            reset_n;
    side_ram_t       mon;
    side_ram_t       sri;
    logic            base_written;
    logic            restore_valid;
    hiscore_offset_t restore_offset;
    logic [7:0]      restore_data;
    logic            restore_ready;
    logic            restore_done;
    logic            save_rd;
    hiscore_offset_t save_offset;
    logic            save_rd_valid;
    logic [7:0]      save_rd_data;
    logic            busy;
    logic            injected;
`ifdef ATHENA_HISCORE_CHECKSUM_EN
    logic [7:0]      checksum;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam side_ram_t IDLE = '{nCS: 1'b1, nWE: 1'b1, addr: 16'h0000, data_in: 8'h00};
    localparam side_ram_t PROBE = '{nCS: 1'b0, nWE: 1'b1, addr: 16'h1234, data_in: 8'hAB};

    always #5 game_clk = ~game_clk;

    athena_hiscore_shadow dut (
        .game_clk         (game_clk),
        .reset_n          (reset_n),
        .side_ram_monitor (mon),
        .side_ram_in      (sri),
        .base_written     (base_written),
        .restore_valid    (restore_valid),
        .restore_offset   (restore_offset),
        .restore_data     (restore_data),
        .restore_ready    (restore_ready),
        .restore_done     (restore_done),
        .save_rd          (save_rd),
        .save_offset      (save_offset),
        .save_rd_valid    (save_rd_valid),
        .save_rd_data     (save_rd_data),
        .busy             (busy),
        .injected         (injected)
`ifdef ATHENA_HISCORE_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge game_clk);
        #1;
    endtask

    task automatic gwrite(input logic [15:0] a, input logic [7:0] d);
        mon = '{nCS: 1'b0, nWE: 1'b0, addr: a, data_in: d};
        tick();
        mon = IDLE;
    endtask

    task automatic rd(input string tag, input int off, input logic [7:0] exp);
        save_rd     = 1'b1;
        save_offset = 7'(off);
        tick();
        chk(tag, 32'({save_rd_valid, save_rd_data}), 32'({1'b1, exp}));
        save_rd = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] xv);
        for (int i = 0; i < 114; i++) begin
            restore_valid  = 1'b1;
            restore_offset = 7'(i);
            restore_data   = 8'(i) ^ xv;
            tick();
        end
        restore_valid = 1'b0;
    endtask

    task automatic done_pulse();
        restore_done = 1'b1;
        tick();
        restore_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        restore_valid = 1'b0;
        restore_done  = 1'b0;
        base_written  = 1'b0;
        save_rd       = 1'b0;
        mon           = IDLE;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int nw;
        int nbusy;
        int errs;
        int ov;
        bit prev;

        reset_n        = 1'b0;
        base_written   = 1'b0;
        restore_valid  = 1'b0;
        restore_offset = '0;
        restore_data   = '0;
        restore_done   = 1'b0;
        save_rd        = 1'b0;
        save_offset    = '0;
        mon            = PROBE;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_injected", 32'(injected), 32'(0));
        chk("rst_rd", 32'({save_rd_valid, save_rd_data}), 32'(0));
        chk("rst_pass", 32'(sri), 32'(PROBE));
        reset_n = 1'b1;
        mon     = IDLE;
        tick();
        chk("load_ready", 32'(restore_ready), 32'(1));

        // No restore: empty save file completes immediately
        done_pulse();
        chk("nr_injected", 32'(injected), 32'(1));
        chk("nr_busy", 32'(busy), 32'(0));
        mon = '{nCS: 1'b0, nWE: 1'b0, addr: 16'h0650, data_in: 8'hEB};
        #1;
        chk("nr_pass_wr", 32'(sri), 32'(mon));
        tick();
        mon = IDLE;
        gwrite(16'h06C1, 8'hFF);
        rd("nr_off0", 0, 8'hEB);
        rd("nr_off113", 113, 8'hFF);

        // Out-of-range and read-only accesses must leave the shadow alone
        gwrite(16'h064F, 8'h11);
        gwrite(16'h06C2, 8'h22);
        gwrite(16'h05D0, 8'h33);
        gwrite(16'h06D0, 8'h44);
        mon = '{nCS: 1'b0, nWE: 1'b1, addr: 16'h0650, data_in: 8'h77};
        tick();
        mon = IDLE;
        rd("oor_rd114", 114, 8'hFF);
        save_rd     = 1'b1;
        save_offset = 7'd0;
        tick();
        chk("b2b_off0", 32'({save_rd_valid, save_rd_data}), 32'({1'b1, 8'hEB}));
        save_offset = 7'd113;
        tick();
        chk("b2b_off113", 32'({save_rd_valid, save_rd_data}), 32'({1'b1, 8'hFF}));
        save_rd = 1'b0;
        tick();
        chk("rd_valid_drop", 32'(save_rd_valid), 32'(0));

        // Full restore
        do_reset();
        restore_valid  = 1'b1;
        restore_offset = 7'd120;
        restore_data   = 8'h99;
        #1;
        chk("oor_restore_ready", 32'(restore_ready), 32'(1));
        tick();
        restore_offset = 7'd2;
        restore_data   = 8'h77;
        mon = '{nCS: 1'b0, nWE: 1'b0, addr: 16'h0651, data_in: 8'h66};
        #1;
        chk("collide_ready", 32'(restore_ready), 32'(0));
        tick();
        mon = IDLE;
        tick();
        restore_valid = 1'b0;
        load_all(8'h5A);
        done_pulse();
        chk("wb_busy", 32'(busy), 32'(0));
        chk("wb_ready", 32'(restore_ready), 32'(0));
        chk("wb_injected", 32'(injected), 32'(0));
        gwrite(16'h0650, 8'h00);
        rd("wb_capture", 0, 8'h00);
        base_written = 1'b1;
        nw = 0; nbusy = 0; errs = 0; prev = 1'b0;
        for (int c = 0; c < 400 && !injected; c++) begin
            if (busy) nbusy++;
            if (!sri.nCS && !sri.nWE) begin
                if (sri.addr !== 16'(16'h0650 + nw) || sri.data_in !== (8'(nw) ^ 8'h5A) || prev)
                    errs++;
                nw++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
            tick();
        end
        chk("full_writes", 32'(nw), 32'(114));
        chk("full_busy_cycles", 32'(nbusy), 32'(228));
        chk("full_write_errs", 32'(errs), 32'(0));
        chk("full_injected", 32'(injected), 32'(1));
        rd("full_off0", 0, 8'h5A);
        rd("full_off2", 2, 8'h58);
        rd("full_off113", 113, 8'h2B);
        rd("full_rd114", 114, 8'hFF);

        // Contention: game on the bus every other cycle
        do_reset();
        load_all(8'hA5);
        done_pulse();
        base_written = 1'b1;
        nw = 0; errs = 0; ov = 0;
        for (int c = 0; c < 1000 && !injected; c++) begin
            mon = c[0] ? '{nCS: 1'b0, nWE: 1'b1, addr: 16'h0100, data_in: 8'h00} : IDLE;
            #1;
            if (!mon.nCS) begin
                if (sri !== mon) ov++;
            end else if (!sri.nCS) begin
                if (sri.addr !== 16'(16'h0650 + nw) || sri.data_in !== (8'(nw) ^ 8'hA5))
                    errs++;
                nw++;
            end
            @(posedge game_clk);
            #1;
        end
        mon = IDLE;
        chk("cont_writes", 32'(nw), 32'(114));
        chk("cont_overlap", 32'(ov), 32'(0));
        chk("cont_write_errs", 32'(errs), 32'(0));
        chk("cont_injected", 32'(injected), 32'(1));
        gwrite(16'h0660, 8'hC3);
        rd("cont_off10", 16, 8'hC3);
        rd("cont_off11", 17, 8'hB4);

        // Reset in the middle of injection
        do_reset();
        load_all(8'h3C);
        done_pulse();
        base_written = 1'b1;
        nw = 0;
        for (int c = 0; c < 300 && nw < 40; c++) begin
            if (!sri.nCS && !sri.nWE) nw++;
            tick();
        end
        chk("mid_reached40", 32'(nw), 32'(40));
        reset_n = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_injected", 32'(injected), 32'(0));
        reset_n      = 1'b1;
        base_written = 1'b0;
        mon          = PROBE;
        #1;
        chk("mid_ready", 32'(restore_ready), 32'(1));
        chk("mid_pass", 32'(sri), 32'(PROBE));
        mon = IDLE;
        tick();
        done_pulse();
        chk("mid_buf_invalid", 32'(injected), 32'(1));
        rd("mid_off39", 39, 8'h1B);

`ifdef ATHENA_HISCORE_CHECKSUM_EN
        do_reset();
        for (int i = 0; i < 114; i++) gwrite(16'(16'h0650 + i), 8'h00);
        do_reset();
        chk("cs_reset", 32'(checksum), 32'(0));
        gwrite(16'h0650, 8'h10);
        chk("cs_first", 32'(checksum), 32'(8'h10));
        gwrite(16'h0650, 8'h30);
        chk("cs_overwrite", 32'(checksum), 32'(8'h30));
        gwrite(16'h0651, 8'hF0);
        chk("cs_wrap", 32'(checksum), 32'(8'h20));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
